// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, drives the instruction-memory word
// address, and buffers fetched {pc, instr} pairs in a small prefetch FIFO
// that decode drains over a valid/ready handshake.
module instruction_fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     redirect_vld,
  input  logic [63:0]              redirect_pc,
  output logic [63:0]              imem_addr,
  input  logic [31:0]              imem_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [63:0]              out_pc,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     halted,
  output logic                     misalign_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [31:0]   ECALL    = 32'h0000_0073;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALT
  } state_t;

  state_t        state_q, state_d;
  logic [63:0]   pc_q, pc_d;
  logic [AW-1:0] head_q, head_d, tail;
  logic [CW-1:0] count_q, count_d, count_after_pop;
  logic [31:0]   instr_mem [DEPTH];
  logic [63:0]   pc_mem    [DEPTH];
  logic          pop, redir, fetch;
  logic [31:0]   out_instr_d;
  logic [63:0]   out_pc_d;

  assign imem_addr  = {2'b00, pc_q[63:2]};
  assign fifo_count = count_q;

  // Next-state logic: handshake, fetch decision, FIFO bookkeeping and FSM.
  always_comb begin
    pop             = out_valid && out_ready;
    redir           = redirect_vld && (state_q != S_IDLE);
    fetch           = (state_q == S_RUN) && ((count_q != FULL_CNT) || pop) && !redir;
    tail            = head_q + count_q[AW-1:0];
    head_d          = head_q + AW'(pop);
    count_after_pop = count_q - CW'(pop);
    count_d         = redir ? '0 : count_after_pop + CW'(fetch);

    // Output registers track the post-edge head; when the FIFO drains
    // empty before this push, the new head is the word being pushed now.
    out_instr_d = out_instr;
    out_pc_d    = out_pc;
    if (count_d != '0) begin
      if (count_after_pop == '0) begin
        out_instr_d = imem_data;
        out_pc_d    = pc_q;
      end else begin
        out_instr_d = instr_mem[head_d];
        out_pc_d    = pc_mem[head_d];
      end
    end

    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RUN;
      end
      S_RUN, S_HALT: begin
        if (redir) begin
          state_d = S_RUN;
          pc_d    = {redirect_pc[63:2], 2'b00};
        end else if (fetch) begin
          pc_d = pc_q + 64'd4;
          if (imem_data == ECALL) state_d = S_HALT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO payload storage; written only on a fetch, needs no reset.
  always_ff @(posedge clk) begin
    if (fetch) begin
      instr_mem[tail] <= imem_data;
      pc_mem[tail]    <= pc_q;
    end
  end

  // Control state, pointers and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      head_q       <= '0;
      count_q      <= '0;
      out_valid    <= 1'b0;
      out_instr    <= '0;
      out_pc       <= '0;
      halted       <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      head_q       <= head_d;
      count_q      <= count_d;
      out_valid    <= (count_d != '0);
      out_instr    <= out_instr_d;
      out_pc       <= out_pc_d;
      halted       <= (state_d == S_HALT);
      misalign_err <= redir && (redirect_pc[1:0] != 2'b00);
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Testbench for instruction_fetch_unit: randomized stimulus, queue-based
// reference model of the prefetch FIFO, and a negedge scoreboard monitor.
module tb_instruction_fetch_unit;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] ECALL = 32'h0000_0073;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic        redirect_vld;
  logic [63:0] redirect_pc;
  logic [63:0] imem_addr;
  logic [31:0] imem_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic [2:0]  fifo_count;
  logic        halted;
  logic        misalign_err;

  logic [31:0] mem [64];
  assign imem_data = mem[imem_addr[5:0]];

  instruction_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(64'h0)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .redirect_vld (redirect_vld),
    .redirect_pc  (redirect_pc),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_instr    (out_instr),
    .out_pc       (out_pc),
    .fifo_count   (fifo_count),
    .halted       (halted),
    .misalign_err (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: expected FIFO contents as a queue plus program state.
  ent_t        q[$];
  ent_t        last;
  logic [63:0] mpc;
  int          mst;
  logic        mmis;
  logic        popped;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    last   = '0;
    mpc    = 64'h0;
    mst    = M_IDLE;
    mmis   = 1'b0;
    popped = 1'b0;
  endtask

  // Apply the effect of the clock edge just taken, using the inputs held across it.
  task automatic model_edge();
    int   pre;
    logic redir;
    ent_t e;
    pre   = q.size() + (popped ? 1 : 0);
    redir = redirect_vld && (mst != M_IDLE);
    mmis  = redir && (redirect_pc[1:0] != 2'b00);
    if (redir) begin
      q.delete();
      mpc = {redirect_pc[63:2], 2'b00};
      mst = M_RUN;
    end else if (mst == M_RUN && (pre < DEPTH || popped)) begin
      e.pc    = mpc;
      e.instr = mem[mpc[7:2]];
      q.push_back(e);
      if (e.instr == ECALL) mst = M_HALT;
      mpc = mpc + 64'd4;
    end else if (mst == M_IDLE && start) begin
      mst = M_RUN;
    end
    popped = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (reset) model_reset();
    else model_edge();
  endtask

  task automatic redirect_to(input logic [63:0] target);
    redirect_vld = 1'b1;
    redirect_pc  = target;
    step();
    redirect_vld = 1'b0;
  endtask

  // Scoreboard monitor: compares presented outputs against the model, pops on handshake.
  always @(negedge clk) begin
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    chk("fifo_count", 64'(fifo_count), 64'(q.size()));
    chk("imem_addr", imem_addr, {2'b00, mpc[63:2]});
    chk("halted", 64'(halted), 64'(mst == M_HALT));
    chk("misalign_err", 64'(misalign_err), 64'(mmis));
    if (q.size() != 0) begin
      chk("out_pc", out_pc, q[0].pc);
      chk("out_instr", 64'(out_instr), 64'(q[0].instr));
      last = q[0];
      if (out_ready && !reset) begin
        void'(q.pop_front());
        popped = 1'b1;
      end
    end else begin
      chk("out_pc_hold", out_pc, last.pc);
      chk("out_instr_hold", 64'(out_instr), 64'(last.instr));
    end
  end

  logic [31:0] saved;

  initial begin
    for (int i = 0; i < 64; i++) begin
      logic [31:0] w;
      w = $urandom;
      if (i >= 8 && $urandom_range(0, 15) == 0) w = ECALL;
      if (i < 8 && w == ECALL) w = 32'h1;
      mem[i] = w;
    end
    reset        = 1'b1;
    start        = 1'b0;
    redirect_vld = 1'b0;
    redirect_pc  = '0;
    out_ready    = 1'b0;
    model_reset();
    repeat (2) step();
    reset = 1'b0;
    step();

    // Redirect ignored while idle.
    redirect_vld = 1'b1;
    redirect_pc  = 64'h40;
    step();
    redirect_vld = 1'b0;

    // Sequential fetch with a free-running consumer.
    start     = 1'b1;
    out_ready = 1'b1;
    repeat (8) step();

    // Consumer stalls: FIFO fills and the PC holds.
    redirect_to(64'h0);
    out_ready = 1'b0;
    repeat (10) step();

    // Full FIFO with simultaneous pop and fetch.
    out_ready = 1'b1;
    repeat (4) step();

    // Redirect with entries queued and pop active, then a misaligned redirect.
    out_ready = 1'b0;
    redirect_to(64'h0);
    repeat (3) step();
    out_ready = 1'b1;
    redirect_to(64'h1C);
    repeat (3) step();
    redirect_to(64'h1E);
    repeat (3) step();

    // ecall at word 3 halts the fetch; a redirect resumes it.
    saved  = mem[3];
    mem[3] = ECALL;
    redirect_to(64'h0);
    repeat (10) step();
    mem[3] = saved;
    redirect_to(64'h0);
    repeat (3) step();

    // Asynchronous reset mid-run with three entries queued.
    out_ready = 1'b0;
    redirect_to(64'h0);
    repeat (3) step();
    #2;
    reset = 1'b1;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_instr", 64'(out_instr), 64'd0);
    chk("rst_out_pc", out_pc, 64'd0);
    chk("rst_fifo_count", 64'(fifo_count), 64'd0);
    chk("rst_imem_addr", imem_addr, 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_misalign", 64'(misalign_err), 64'd0);
    model_reset();
    step();
    reset = 1'b0;
    step();

    // Randomized traffic: random consumer stalls and redirects, incl. wrap targets.
    for (int n = 0; n < 800; n++) begin
      out_ready    = ($urandom_range(0, 3) != 0);
      redirect_vld = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 9) == 0)
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
      else
        redirect_pc = 64'($urandom_range(0, 255));
      step();
    end
    redirect_vld = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
